mem_port_arbiter: RTL and testbench

//  Shares one single-port Memory instance (async read, sync write) between the

---
 rtl/mem_port_arbiter.sv | 109 ++++++++++
 tb/tb_mem_port_arbiter.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port memory between the fetch port and the load/store
// port, stretching every access to LATENCY cycles.
module mem_port_arbiter #(
  parameter int LATENCY      = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ready,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ready,
  output logic [31:0] d_rdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_din,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [31:0] mem_dout
);

  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt;
  logic [SW-1:0]   starve;
  logic            own_f;
  logic            we_q;
  logic [31:0]     addr_q;
  logic [31:0]     wdata_q;
  logic            any_req;
  logic            grant_f;
  logic            last;

  // Data normally wins; fetch only when it is alone or has waited long enough.
  assign any_req = if_req | d_req;
  assign grant_f = if_req && (!d_req || starve == SW'(STARVE_LIMIT));
  assign last    = (state == ACCESS) && (cnt == '0);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:   if (any_req) state_nxt = ACCESS;
      ACCESS: if (cnt == '0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt     <= '0;
      starve  <= '0;
      own_f   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (state == IDLE && any_req) begin
      own_f   <= grant_f;
      addr_q  <= grant_f ? if_addr : d_addr;
      we_q    <= !grant_f && d_we;
      wdata_q <= grant_f ? 32'h0 : d_wdata;
      cnt     <= CW'(LATENCY - 1);
      if (grant_f || !if_req)           starve <= '0;
      else if (starve != SW'(STARVE_LIMIT)) starve <= starve + SW'(1);
    end else if (state == ACCESS && cnt != '0) begin
      cnt <= cnt - CW'(1);
    end
  end

  // Stores write only on the final ACCESS cycle so an aborted access never commits.
  always_comb begin
    mem_addr  = '0;
    mem_din   = '0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    if_ready  = 1'b0;
    if_rdata  = '0;
    d_ready   = 1'b0;
    d_rdata   = '0;
    if (state == ACCESS) begin
      mem_addr  = addr_q;
      mem_din   = wdata_q;
      mem_read  = !we_q;
      mem_write = we_q && last;
      if (last) begin
        if (own_f) begin
          if_ready = 1'b1;
          if_rdata = mem_dout;
        end else begin
          d_ready = 1'b1;
          if (!we_q) d_rdata = mem_dout;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: two instances (LATENCY=1 and LATENCY=3), each
// backed by a behavioural async-read / sync-write memory.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic reset, mem_clr;
  always #5 clk = ~clk;

  logic        a_if_req, a_if_ready, a_d_req, a_d_we, a_d_ready, a_mem_read, a_mem_write;
  logic [31:0] a_if_addr, a_if_rdata, a_d_addr, a_d_wdata, a_d_rdata, a_mem_addr, a_mem_din, a_mem_dout;
  logic        b_if_req, b_if_ready, b_d_req, b_d_we, b_d_ready, b_mem_read, b_mem_write;
  logic [31:0] b_if_addr, b_if_rdata, b_d_addr, b_d_wdata, b_d_rdata, b_mem_addr, b_mem_din, b_mem_dout;

  logic [31:0] a_mem [256];
  logic [31:0] b_mem [256];

  mem_port_arbiter #(.LATENCY(1), .STARVE_LIMIT(4)) u_a (
    .clk(clk), .reset(reset),
    .if_req(a_if_req), .if_addr(a_if_addr), .if_ready(a_if_ready), .if_rdata(a_if_rdata),
    .d_req(a_d_req), .d_we(a_d_we), .d_addr(a_d_addr), .d_wdata(a_d_wdata),
    .d_ready(a_d_ready), .d_rdata(a_d_rdata),
    .mem_addr(a_mem_addr), .mem_din(a_mem_din), .mem_read(a_mem_read),
    .mem_write(a_mem_write), .mem_dout(a_mem_dout));

  mem_port_arbiter #(.LATENCY(3), .STARVE_LIMIT(4)) u_b (
    .clk(clk), .reset(reset),
    .if_req(b_if_req), .if_addr(b_if_addr), .if_ready(b_if_ready), .if_rdata(b_if_rdata),
    .d_req(b_d_req), .d_we(b_d_we), .d_addr(b_d_addr), .d_wdata(b_d_wdata),
    .d_ready(b_d_ready), .d_rdata(b_d_rdata),
    .mem_addr(b_mem_addr), .mem_din(b_mem_din), .mem_read(b_mem_read),
    .mem_write(b_mem_write), .mem_dout(b_mem_dout));

  assign a_mem_dout = a_mem[a_mem_addr[9:2]];
  assign b_mem_dout = b_mem[b_mem_addr[9:2]];

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 256; i++) begin
        a_mem[i] <= 32'hA000_0000 | i;
        b_mem[i] <= 32'hA000_0000 | i;
      end
    end else begin
      if (a_mem_write) a_mem[a_mem_addr[9:2]] <= a_mem_din;
      if (b_mem_write) b_mem[b_mem_addr[9:2]] <= b_mem_din;
    end
  end

  typedef struct {
    bit          f;
    logic [31:0] rd;
  } exp_t;
  exp_t sbq[$];

  int tests = 0;
  int fails = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Observes one instance until its next ready pulse; reports, does not judge.
  task automatic wait_port(input bit sel, output bit got_f, output bit both,
                           output logic [31:0] rd, output int cyc,
                           output int nwr, output int nrd);
    got_f = 0; both = 0; rd = '0; cyc = -1; nwr = 0; nrd = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      nwr += int'(sel ? b_mem_write : a_mem_write);
      nrd += int'(sel ? b_mem_read  : a_mem_read);
      if (sel ? (b_if_ready || b_d_ready) : (a_if_ready || a_d_ready)) begin
        got_f = sel ? b_if_ready : a_if_ready;
        both  = sel ? (b_if_ready && b_d_ready) : (a_if_ready && a_d_ready);
        rd    = got_f ? (sel ? b_if_rdata : a_if_rdata) : (sel ? b_d_rdata : a_d_rdata);
        cyc   = i;
        return;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1; mem_clr = 1;
    a_if_req = 0; a_if_addr = 0; a_d_req = 0; a_d_we = 0; a_d_addr = 0; a_d_wdata = 0;
    b_if_req = 0; b_if_addr = 0; b_d_req = 0; b_d_we = 0; b_d_addr = 0; b_d_wdata = 0;
    repeat (3) tick();
    tests++;
    if ({a_if_ready, a_if_rdata, a_d_ready, a_d_rdata, a_mem_addr, a_mem_din, a_mem_read, a_mem_write} !== '0) begin
      fails++; $display("FAIL reset_a: outputs not all zero (mem_addr=%h read=%b)", a_mem_addr, a_mem_read);
    end
    tests++;
    if ({b_if_ready, b_if_rdata, b_d_ready, b_d_rdata, b_mem_addr, b_mem_din, b_mem_read, b_mem_write} !== '0) begin
      fails++; $display("FAIL reset_b: outputs not all zero (mem_addr=%h read=%b)", b_mem_addr, b_mem_read);
    end
    reset = 0; mem_clr = 0;
    tick();
  endtask

  task automatic test_store_load();
    bit f, both; logic [31:0] rd; int cyc, nwr, nrd; exp_t e;
    a_d_req = 1; a_d_we = 1; a_d_addr = 32'h10; a_d_wdata = 32'hCAFE;
    sbq.push_back('{0, 32'h0});
    wait_port(0, f, both, rd, cyc, nwr, nrd);
    a_d_req = 0;
    tests++;
    if (cyc !== 1) begin fails++; $display("FAIL store_latency: got %0d cycles, want 1", cyc); end
    tests++;
    if (nwr !== 1) begin fails++; $display("FAIL store_write_count: got %0d, want 1", nwr); end
    e = sbq.pop_front();
    tests++;
    if (f !== e.f || rd !== e.rd) begin fails++; $display("FAIL store_ready: port_f=%b rd=%h want port_f=%b rd=%h", f, rd, e.f, e.rd); end
    tick();
    a_d_req = 1; a_d_we = 0;
    sbq.push_back('{0, 32'hCAFE});
    wait_port(0, f, both, rd, cyc, nwr, nrd);
    a_d_req = 0;
    e = sbq.pop_front();
    tests++;
    if (f !== e.f || rd !== e.rd || cyc !== 1) begin
      fails++; $display("FAIL load_back: port_f=%b rd=%h cyc=%0d want port_f=%b rd=%h cyc=1", f, rd, cyc, e.f, e.rd);
    end
    tests++;
    if (nwr !== 0 || a_mem[4] !== 32'hCAFE) begin
      fails++; $display("FAIL store_commit: extra writes=%0d mem=%h want 0 / 0000cafe", nwr, a_mem[4]);
    end
    tick();
  endtask

  task automatic test_simultaneous();
    bit f, both; logic [31:0] rd; int cyc, nwr, nrd; exp_t e;
    a_if_req = 1; a_if_addr = 32'h10;
    a_d_req = 1; a_d_we = 0; a_d_addr = 32'h8;
    sbq.push_back('{0, 32'hA000_0002});
    sbq.push_back('{1, 32'hCAFE});
    wait_port(0, f, both, rd, cyc, nwr, nrd);
    a_d_req = 0;
    e = sbq.pop_front();
    tests++;
    if (f !== e.f || rd !== e.rd || cyc !== 1) begin
      fails++; $display("FAIL simul_first: port_f=%b rd=%h cyc=%0d want port_f=%b rd=%h cyc=1", f, rd, cyc, e.f, e.rd);
    end
    wait_port(0, f, both, rd, cyc, nwr, nrd);
    a_if_req = 0;
    e = sbq.pop_front();
    tests++;
    if (f !== e.f || rd !== e.rd || cyc !== 2) begin
      fails++; $display("FAIL simul_second: port_f=%b rd=%h cyc=%0d want port_f=%b rd=%h cyc=2", f, rd, cyc, e.f, e.rd);
    end
    tick();
  endtask

  task automatic test_starvation();
    bit f, both; logic [31:0] rd; int cyc, nwr, nrd; exp_t e;
    bit pat [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
    a_if_req = 1; a_if_addr = 32'h4;
    a_d_req = 1; a_d_we = 0; a_d_addr = 32'h0;
    for (int k = 0; k < 10; k++)
      sbq.push_back('{pat[k], pat[k] ? 32'hA000_0001 : 32'hA000_0000});
    for (int k = 0; k < 10; k++) begin
      wait_port(0, f, both, rd, cyc, nwr, nrd);
      if (k == 9) begin a_if_req = 0; a_d_req = 0; end
      e = sbq.pop_front();
      tests++;
      if (f !== e.f || rd !== e.rd || both || cyc !== (k == 0 ? 1 : 2)) begin
        fails++; $display("FAIL starve_grant%0d: port_f=%b rd=%h both=%b cyc=%0d want port_f=%b rd=%h", k, f, rd, both, cyc, e.f, e.rd);
      end
    end
    tick();
  endtask

  task automatic test_latency();
    bit f, both; logic [31:0] rd; int cyc, nwr, nrd; exp_t e;
    b_if_req = 1; b_if_addr = 32'h0;
    sbq.push_back('{1, 32'hA000_0000});
    wait_port(1, f, both, rd, cyc, nwr, nrd);
    b_if_req = 0;
    e = sbq.pop_front();
    tests++;
    if (f !== e.f || rd !== e.rd || cyc !== 3) begin
      fails++; $display("FAIL lat3_fetch: port_f=%b rd=%h cyc=%0d want port_f=%b rd=%h cyc=3", f, rd, cyc, e.f, e.rd);
    end
    tests++;
    if (nrd !== 3) begin fails++; $display("FAIL lat3_mem_read: high %0d cycles, want 3", nrd); end
    tick();
  endtask

  task automatic test_reset_abort();
    bit f, both; logic [31:0] rd; int cyc, nwr, nrd; int seen; exp_t e;
    seen = 0;
    b_d_req = 1; b_d_we = 1; b_d_addr = 32'h20; b_d_wdata = 32'hDEAD;
    tick(); seen += int'(b_mem_write || b_d_ready);
    tick(); seen += int'(b_mem_write || b_d_ready);
    reset = 1; b_d_req = 0;
    tick();
    tests++;
    if ({b_if_ready, b_if_rdata, b_d_ready, b_d_rdata, b_mem_addr, b_mem_din, b_mem_read, b_mem_write} !== '0) begin
      fails++; $display("FAIL abort_outputs: not zero (mem_addr=%h write=%b)", b_mem_addr, b_mem_write);
    end
    reset = 0;
    repeat (4) begin tick(); seen += int'(b_mem_write || b_d_ready || b_mem_read); end
    tests++;
    if (seen !== 0 || b_mem[8] !== 32'hA000_0008) begin
      fails++; $display("FAIL abort_no_write: activity=%0d mem=%h want 0 / a0000008", seen, b_mem[8]);
    end
    b_d_req = 1; b_d_we = 0;
    sbq.push_back('{0, 32'hA000_0008});
    wait_port(1, f, both, rd, cyc, nwr, nrd);
    b_d_req = 0;
    e = sbq.pop_front();
    tests++;
    if (f !== e.f || rd !== e.rd || cyc !== 3) begin
      fails++; $display("FAIL abort_readback: port_f=%b rd=%h cyc=%0d want port_f=%b rd=%h cyc=3", f, rd, cyc, e.f, e.rd);
    end
    tick();
  endtask

  task automatic test_drop_req();
    int pulses, nrd; logic [31:0] rd; exp_t e;
    pulses = 0; rd = '0;
    b_d_req = 1; b_d_we = 0; b_d_addr = 32'h8;
    sbq.push_back('{0, 32'hA000_0002});
    tick();
    nrd = int'(b_mem_read);
    b_d_req = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      nrd += int'(b_mem_read);
      if (b_d_ready) begin pulses++; rd = b_d_rdata; end
      if (b_if_ready) pulses += 100;
    end
    tests++;
    if (pulses !== 1 || nrd !== 3) begin
      fails++; $display("FAIL drop_req: pulses=%0d reads=%0d want 1 / 3", pulses, nrd);
    end
    e = sbq.pop_front();
    tests++;
    if (rd !== e.rd) begin fails++; $display("FAIL drop_rdata: got %h want %h", rd, e.rd); end
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_simultaneous();
    test_starvation();
    test_latency();
    test_reset_abort();
    test_drop_req();
    tests++;
    if (sbq.size() !== 0) begin fails++; $display("FAIL scoreboard_drain: %0d left, want 0", sbq.size()); end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
